// File: rtl/cardinal_pkg.sv
// Shared Cardinal core definitions: latency classes, ALU function codes, opcodes
// and the EX_MEM latency controller state encoding.
package cardinal_pkg;

   typedef enum logic [2:0] {
      CLS_SINGLE = 3'd0,
      CLS_A3     = 3'd1,
      CLS_A4     = 3'd2,
      CLS_A5     = 3'd3,
      CLS_MEM    = 3'd4
   } lat_class_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_SLL  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_SRA  = 4'd6,
      ALU_MUL  = 4'd7,
      ALU_MOD  = 4'd8,
      ALU_SQ   = 4'd9,
      ALU_DIV  = 4'd10,
      ALU_SQRT = 4'd11
   } alu_func_e;

   localparam logic [5:0] OP_RTYPE = 6'b101010;
   localparam logic [5:0] OP_LOAD  = 6'b100000;
   localparam logic [5:0] OP_STORE = 6'b100001;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ALU_BUSY = 2'd1,
      ST_MEM_WAIT = 2'd2
   } exm_state_e;

   function automatic logic is_mem_class(input logic [2:0] cls);
      return cls == CLS_MEM;
   endfunction

endpackage

// File: rtl/cardinal_lat_counter.sv
// Shared EX_MEM cycle counter: synchronous clear beats enable; at_term flags
// a match against the terminal value selected by the owner.
module cardinal_lat_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] cnt,
   output logic             at_term
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_term = (cnt == term);

endmodule

// File: rtl/cardinal_exm_latency_ctrl.sv
// EX_MEM latency controller: per-class programmable ALU latency, dmem ack
// handshake with timeout, pipeline stall and WB bubble/data select.
module cardinal_exm_latency_ctrl
   import cardinal_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 32,
   parameter int LAT_A3  = 3,
   parameter int LAT_A4  = 4,
   parameter int LAT_A5  = 5,
   parameter int CNT_W   = 4,
   parameter int MEM_TMO = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              exm_valid,
   input  logic [2:0]        exm_class,
   input  logic [4:0]        exm_rd,
   input  logic              exm_rf_wr,
   input  logic              exm_mem_wr,
   input  logic [ADDR_W-1:0] exm_addr,
   input  logic [DATA_W-1:0] exm_wdata,
   input  logic [DATA_W-1:0] alu_result,
   output logic              dmem_En,
   output logic              dmem_WrEn,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_data_out,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_data_in,
   output logic              stall_pipeline,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_tmo_err,
   output logic [31:0]       stall_cycles
);

   exm_state_e        state, state_nx;
   logic [CNT_W-1:0]  eff_lat, lat_m2, cnt, cnt_term;
   logic              at_term, cnt_en, is_mem;
   logic              stall_c, tmo_c, mem_act;
   logic              sh_wr;
   logic [ADDR_W-1:0] sh_addr;
   logic [DATA_W-1:0] sh_data;
   logic              tmo_err_q;
   logic [31:0]       stall_cnt_q;

   localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(MEM_TMO - 1);

   assign is_mem = exm_valid && is_mem_class(exm_class);

   // r0 destinations and unknown classes complete in a single EX cycle.
   always_comb begin
      eff_lat = CNT_W'(1);
      if (exm_valid && exm_rd != 5'd0) begin
         case (exm_class)
            CLS_A3:  eff_lat = CNT_W'(LAT_A3);
            CLS_A4:  eff_lat = CNT_W'(LAT_A4);
            CLS_A5:  eff_lat = CNT_W'(LAT_A5);
            default: eff_lat = CNT_W'(1);
         endcase
      end
   end

   assign lat_m2   = (eff_lat > CNT_W'(2)) ? eff_lat - CNT_W'(2) : '0;
   assign cnt_term = (state == ST_ALU_BUSY) ? lat_m2 : TMO_M1;

   cardinal_lat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (!stall_c),
      .en      (cnt_en),
      .term    (cnt_term),
      .cnt     (cnt),
      .at_term (at_term)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      stall_c       = 1'b0;
      cnt_en        = 1'b0;
      tmo_c         = 1'b0;
      mem_act       = 1'b0;
      dmem_En       = 1'b0;
      dmem_WrEn     = 1'b0;
      dmem_addr     = '0;
      dmem_data_out = '0;
      case (state)
         ST_IDLE: begin
            if (is_mem) begin
               mem_act       = 1'b1;
               dmem_En       = 1'b1;
               dmem_WrEn     = exm_mem_wr;
               dmem_addr     = exm_addr;
               dmem_data_out = exm_wdata;
               if (!dmem_ack) begin
                  if (at_term) begin
                     tmo_c = 1'b1;
                  end else begin
                     stall_c  = 1'b1;
                     cnt_en   = 1'b1;
                     state_nx = ST_MEM_WAIT;
                  end
               end
            end else if (eff_lat > CNT_W'(1)) begin
               stall_c  = 1'b1;
               state_nx = ST_ALU_BUSY;
            end
         end
         ST_ALU_BUSY: begin
            if (at_term) begin
               state_nx = ST_IDLE;
            end else begin
               stall_c = 1'b1;
               cnt_en  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            mem_act       = 1'b1;
            dmem_En       = 1'b1;
            dmem_WrEn     = sh_wr;
            dmem_addr     = sh_addr;
            dmem_data_out = sh_data;
            if (dmem_ack) begin
               state_nx = ST_IDLE;
            end else if (at_term) begin
               tmo_c    = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               stall_c = 1'b1;
               cnt_en  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      // Reset wins combinationally so an in-flight access is dropped at once.
      if (reset) begin
         state_nx      = ST_IDLE;
         stall_c       = 1'b0;
         cnt_en        = 1'b0;
         tmo_c         = 1'b0;
         mem_act       = 1'b0;
         dmem_En       = 1'b0;
         dmem_WrEn     = 1'b0;
         dmem_addr     = '0;
         dmem_data_out = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_wr   <= 1'b0;
         sh_addr <= '0;
         sh_data <= '0;
      end else if (state == ST_IDLE && state_nx == ST_MEM_WAIT) begin
         sh_wr   <= exm_mem_wr;
         sh_addr <= exm_addr;
         sh_data <= exm_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (tmo_c) begin
            tmo_err_q <= 1'b1;
         end
         if (stall_c && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign stall_pipeline = stall_c;
   assign wb_valid       = !reset && exm_valid && exm_rf_wr && !stall_c;
   assign mem_tmo_err    = reset ? 1'b0 : tmo_err_q;
   assign stall_cycles   = reset ? 32'd0 : stall_cnt_q;

   always_comb begin
      wb_data = alu_result;
      if (reset) begin
         wb_data = '0;
      end else if (mem_act && !dmem_WrEn && dmem_ack) begin
         wb_data = dmem_data_in;
      end else if (mem_act && !dmem_WrEn && tmo_c) begin
         wb_data = '0;
      end
   end

endmodule
